// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: opcodes, FSM states and
// the datapath mux-select enums.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_HALT   = 7'b1111111;

  typedef enum logic [4:0] {
    S_BOOT, S_FETCH, S_DECODE, S_EX_R, S_EX_I, S_MEM_ADDR, S_MEM_RD,
    S_MEM_WB, S_MEM_WR, S_ALU_WB, S_BRANCH, S_JAL, S_JALR_CALC, S_JALR,
    S_LUI, S_HALT, S_TRAP
  } state_t;

  typedef enum logic [1:0] {SRCA_PC = 2'b00, SRCA_RS1 = 2'b01, SRCA_OLDPC = 2'b10} alu_src_a_t;
  typedef enum logic [1:0] {SRCB_RS2 = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10} alu_src_b_t;
  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_BRANCH = 2'b01, ALU_FUNCT = 2'b10} alu_op_t;
  typedef enum logic [1:0] {PC_ALU = 2'b00, PC_ALUOUT = 2'b01, PC_ALUOUT_ALIGN = 2'b10} pc_src_t;
  typedef enum logic [1:0] {RW_ALUOUT = 2'b00, RW_MDR = 2'b01, RW_LINK = 2'b10, RW_IMM = 2'b11} rw_sel_t;

  // States whose exit back to FETCH retires an instruction.
  function automatic logic retires(state_t s);
    return (s == S_ALU_WB) || (s == S_MEM_WB) || (s == S_MEM_WR) ||
           (s == S_BRANCH) || (s == S_JAL) || (s == S_JALR) || (s == S_LUI);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive stalled memory cycles; flags the MAX_WAIT-th one.
// A ready in that same cycle suppresses the timeout.
module mem_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic ready,
  output logic timeout
);
  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_stall;

  assign w_stall = req & ~ready;
  assign timeout = w_stall && (r_cnt == CW'(MAX_WAIT - 1));

  // Stall counter: grows while stalled, clears on completion or idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r_cnt <= '0;
    else if (w_stall && !timeout) r_cnt <= r_cnt + CW'(1);
    else                          r_cnt <= '0;
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle RISC-V main control FSM with Moore outputs, memory stall
// timeout, sticky stop flags and a retired-instruction counter.
module mc_controller
  import ctrl_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic [1:0]       rw_sel,
  output logic             halted,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instret
);
  state_t           r_state, w_next;
  logic             w_timeout;
  logic [CNT_W-1:0] r_instret;
  logic             r_halted, r_illegal, r_bus_err;

  mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (mem_req),
    .ready  (mem_ready),
    .timeout(w_timeout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_BOOT;
    else        r_state <= w_next;
  end

  // Next-state logic; a stall timeout overrides any memory state.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_BOOT:      w_next = S_FETCH;
      S_FETCH:     if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_R:              w_next = S_EX_R;
          OP_I:              w_next = S_EX_I;
          OP_LOAD, OP_STORE: w_next = S_MEM_ADDR;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          OP_JALR:           w_next = S_JALR_CALC;
          OP_LUI:            w_next = S_LUI;
          OP_HALT:           w_next = S_HALT;
          default:           w_next = S_TRAP;
        endcase
      end
      S_EX_R, S_EX_I: w_next = S_ALU_WB;
      S_MEM_ADDR:  w_next = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:    if (mem_ready) w_next = S_MEM_WB;
      S_MEM_WR:    if (mem_ready) w_next = S_FETCH;
      S_JALR_CALC: w_next = S_JALR;
      S_ALU_WB, S_MEM_WB, S_BRANCH, S_JAL, S_JALR, S_LUI: w_next = S_FETCH;
      S_HALT:      w_next = S_HALT;
      S_TRAP:      w_next = S_TRAP;
      default:     w_next = S_TRAP;
    endcase
    if (w_timeout) w_next = S_TRAP;
  end

  // Moore output decode; FETCH enables follow mem_ready so IR/PC load on completion.
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    alu_op        = ALU_ADD;
    pc_src        = PC_ALU;
    rw_sel        = RW_ALUOUT;
    case (r_state)
      S_FETCH: begin
        mem_req   = 1'b1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        alu_src_b = SRCB_FOUR;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_EX_R: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_FUNCT;
      end
      S_EX_I: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_FUNCT;
      end
      S_MEM_ADDR, S_JALR_CALC: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        i_or_d  = 1'b1;
      end
      S_ALU_WB: reg_write = 1'b1;
      S_MEM_WB: begin
        reg_write = 1'b1;
        rw_sel    = RW_MDR;
      end
      S_BRANCH: begin
        alu_src_a     = SRCA_RS1;
        alu_op        = ALU_BRANCH;
        pc_write_cond = 1'b1;
        pc_src        = PC_ALUOUT;
      end
      S_JAL: begin
        pc_write  = 1'b1;
        pc_src    = PC_ALUOUT;
        reg_write = 1'b1;
        rw_sel    = RW_LINK;
      end
      S_JALR: begin
        pc_write  = 1'b1;
        pc_src    = PC_ALUOUT_ALIGN;
        reg_write = 1'b1;
        rw_sel    = RW_LINK;
      end
      S_LUI: begin
        reg_write = 1'b1;
        rw_sel    = RW_IMM;
      end
      default: ;
    endcase
  end

  // Retire counter and sticky stop-cause flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instret <= '0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      if (w_next == S_FETCH && retires(r_state)) r_instret <= r_instret + CNT_W'(1);
      if (w_next == S_HALT) r_halted <= 1'b1;
      if (r_state == S_DECODE && w_next == S_TRAP) r_illegal <= 1'b1;
      if (w_timeout) r_bus_err <= 1'b1;
    end
  end

  assign instret = r_instret;
  assign halted  = r_halted;
  assign illegal = r_illegal;
  assign bus_err = r_bus_err;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-cycle output signatures against
// hand-written expectations for each state, plus counter and flag checks.
module tb_mc_controller;

  logic       clk, rst_n, mem_ready;
  logic [6:0] opcode;
  logic       mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, reg_write;
  logic [1:0] alu_src_a, alu_src_b, alu_op, pc_src, rw_sel;
  logic       halted, illegal, bus_err;
  logic [3:0] instret;

  int n_chk  = 0;
  int n_fail = 0;

  mc_controller #(.CNT_W(4), .MAX_WAIT(15)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_src(pc_src), .rw_sel(rw_sel), .halted(halted), .illegal(illegal),
    .bus_err(bus_err), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {req,we,iod,irw,pcw,pcwc,rw, srca,srcb,aluop,pcsrc,rwsel}
  logic [16:0] sig;
  assign sig = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, reg_write,
                alu_src_a, alu_src_b, alu_op, pc_src, rw_sel};

  localparam logic [16:0] E_IDLE   = 17'b0;
  localparam logic [16:0] E_FETCH0 = {7'b1000000, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
  localparam logic [16:0] E_FETCH1 = {7'b1001100, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
  localparam logic [16:0] E_DEC    = {7'b0000000, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
  localparam logic [16:0] E_EXR    = {7'b0000000, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00};
  localparam logic [16:0] E_EXI    = {7'b0000000, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00};
  localparam logic [16:0] E_ALUWB  = {7'b0000001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [16:0] E_MADDR  = {7'b0000000, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00};
  localparam logic [16:0] E_MRD    = {7'b1010000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [16:0] E_MWB    = {7'b0000001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
  localparam logic [16:0] E_MWR    = {7'b1110000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [16:0] E_BR     = {7'b0000010, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00};
  localparam logic [16:0] E_JAL    = {7'b0000101, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10};
  localparam logic [16:0] E_JALR   = {7'b0000101, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10};
  localparam logic [16:0] E_LUI    = {7'b0000001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11};

  localparam logic [6:0] OR = 7'b0110011, OI = 7'b0010011, OLD = 7'b0000011,
                         OST = 7'b0100011, OBR = 7'b1100011, OJAL = 7'b1101111,
                         OJALR = 7'b1100111, OLUI = 7'b0110111, OHALT = 7'b1111111;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs, check this state's outputs, advance past the edge.
  task automatic cyc(input logic rdy, input logic [6:0] op, input string tag, input logic [16:0] exp);
    mem_ready = rdy;
    opcode    = op;
    #1;
    chk(tag, 32'(sig), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst.outs", 32'(sig), 32'(E_IDLE));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b1, 7'd0, "boot", E_IDLE);
  endtask

  initial begin
    rst_n = 1'b1; mem_ready = 1'b0; opcode = 7'd0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst.outs", 32'(sig), 32'(E_IDLE));
    chk("rst.instret", 32'(instret), 0);
    chk("rst.flags", {29'd0, halted, illegal, bus_err}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(1'b0, 7'd0, "boot", E_IDLE);

    // R-type, zero wait: 4 cycles
    cyc(1, OR, "r.fetch", E_FETCH1);
    cyc(1, OR, "r.dec",   E_DEC);
    cyc(1, OR, "r.ex",    E_EXR);
    chk("r.instret_pre", 32'(instret), 0);
    cyc(1, OR, "r.wb",    E_ALUWB);
    chk("r.instret", 32'(instret), 1);

    // I-type
    cyc(1, OI, "i.fetch", E_FETCH1);
    cyc(1, OI, "i.dec",   E_DEC);
    cyc(1, OI, "i.ex",    E_EXI);
    cyc(1, OI, "i.wb",    E_ALUWB);
    chk("i.instret", 32'(instret), 2);

    // Load with 3-cycle ready delay: 8 cycles
    cyc(1, OLD, "ld.fetch", E_FETCH1);
    cyc(1, OLD, "ld.dec",   E_DEC);
    cyc(1, OLD, "ld.addr",  E_MADDR);
    cyc(0, OLD, "ld.rd0",   E_MRD);
    cyc(0, OLD, "ld.rd1",   E_MRD);
    cyc(0, OLD, "ld.rd2",   E_MRD);
    cyc(1, OLD, "ld.rd3",   E_MRD);
    cyc(0, OLD, "ld.wb",    E_MWB);
    chk("ld.instret", 32'(instret), 3);

    // Store, zero wait
    cyc(1, OST, "st.fetch", E_FETCH1);
    cyc(1, OST, "st.dec",   E_DEC);
    cyc(1, OST, "st.addr",  E_MADDR);
    cyc(1, OST, "st.wr",    E_MWR);
    chk("st.instret", 32'(instret), 4);

    // Branch
    cyc(1, OBR, "br.fetch", E_FETCH1);
    cyc(1, OBR, "br.dec",   E_DEC);
    cyc(1, OBR, "br.br",    E_BR);
    chk("br.instret", 32'(instret), 5);

    // JAL then JALR
    cyc(1, OJAL,  "jal.fetch",  E_FETCH1);
    cyc(1, OJAL,  "jal.dec",    E_DEC);
    cyc(1, OJAL,  "jal.jal",    E_JAL);
    cyc(1, OJALR, "jalr.fetch", E_FETCH1);
    cyc(1, OJALR, "jalr.dec",   E_DEC);
    cyc(1, OJALR, "jalr.calc",  E_MADDR);
    cyc(1, OJALR, "jalr.jalr",  E_JALR);
    chk("jalr.instret", 32'(instret), 7);

    // LUI
    cyc(1, OLUI, "lui.fetch", E_FETCH1);
    cyc(1, OLUI, "lui.dec",   E_DEC);
    cyc(1, OLUI, "lui.lui",   E_LUI);
    chk("lui.instret", 32'(instret), 8);

    // Illegal opcode
    cyc(1, 7'b0000000, "ill.fetch", E_FETCH1);
    cyc(1, 7'b0000000, "ill.dec",   E_DEC);
    cyc(1, 7'b0000000, "ill.trap",  E_IDLE);
    chk("ill.flags", {29'd0, halted, illegal, bus_err}, 32'b010);
    chk("ill.instret", 32'(instret), 8);

    // 16 back-to-back LUIs wrap the 4-bit counter 15 -> 0
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cyc(1, OLUI, "wrap.fetch", E_FETCH1);
      cyc(1, OLUI, "wrap.dec",   E_DEC);
      cyc(1, OLUI, "wrap.lui",   E_LUI);
      chk("wrap.instret", 32'(instret), 32'((i + 1) % 16));
    end
    cyc(1, OLUI, "wrap.fetch", E_FETCH1);
    cyc(1, OLUI, "wrap.dec",   E_DEC);
    cyc(1, OLUI, "wrap.lui",   E_LUI);
    chk("wrap.instret1", 32'(instret), 1);

    // HALT: absorbing, no memory traffic, no retire
    cyc(1, OHALT, "halt.fetch", E_FETCH1);
    cyc(1, OHALT, "halt.dec",   E_DEC);
    for (int i = 0; i < 100; i++) cyc(1, OHALT, "halt.idle", E_IDLE);
    chk("halt.flags", {29'd0, halted, illegal, bus_err}, 32'b100);
    chk("halt.instret", 32'(instret), 1);

    // Ready on the 15th stalled cycle wins; timer must clear between accesses
    do_reset();
    for (int i = 0; i < 14; i++) cyc(0, OR, "nto.wait", E_FETCH0);
    cyc(1, OR, "nto.fetch", E_FETCH1);
    cyc(1, OR, "nto.dec",   E_DEC);
    cyc(1, OR, "nto.ex",    E_EXR);
    cyc(1, OR, "nto.wb",    E_ALUWB);
    for (int i = 0; i < 14; i++) cyc(0, OR, "nto.wait2", E_FETCH0);
    cyc(1, OR, "nto.fetch2", E_FETCH1);
    cyc(1, OR, "nto.dec2",   E_DEC);
    chk("nto.flags", {29'd0, halted, illegal, bus_err}, 0);

    // 15 unready cycles in FETCH -> bus error trap
    do_reset();
    for (int i = 0; i < 15; i++) cyc(0, OR, "to.wait", E_FETCH0);
    chk("to.flags", {29'd0, halted, illegal, bus_err}, 32'b001);
    for (int i = 0; i < 20; i++) cyc(1, OR, "to.idle", E_IDLE);

    // Reset in the middle of a stalled store
    do_reset();
    cyc(1, OST, "rs.fetch", E_FETCH1);
    cyc(1, OST, "rs.dec",   E_DEC);
    cyc(1, OST, "rs.addr",  E_MADDR);
    mem_ready = 1'b0;
    #1;
    chk("rs.wr", 32'(sig), 32'(E_MWR));
    #1 rst_n = 1'b0;
    #1;
    chk("rs.async", 32'(sig), 32'(E_IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(1, OR, "rs.boot",  E_IDLE);
    cyc(1, OR, "rs.fetch2", E_FETCH1);
    chk("rs.instret", 32'(instret), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multi-cycle main control unit for the RISC-V core, the successor to the single-cycle combinational controller. It sequences every instruction through fetch, decode, execute, memory and writeback states; holds memory requests in a ready/request handshake; and times out stalled accesses. It also counts retired instructions and stops permanently on HALT, illegal opcode or bus timeout. It sits between the instruction register (opcode input) and the shared-ALU/shared-memory multi-cycle datapath.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.
- `MAX_WAIT`, default 15: maximum number of cycles `mem_req` may stay high without `mem_ready`; must be ≥ 1.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `opcode` in 7: opcode from the instruction register; valid from the DECODE cycle onward.
- `mem_ready` in 1: memory completes the current request this cycle.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: write request; high only together with `mem_req`.
- `i_or_d` out 1: memory address source. 0 = PC, 1 = ALUOut.
- `ir_write`, `pc_write`, `pc_write_cond`, `reg_write` out 1 each: register enables.
- `alu_src_a` out 2: ALU operand A. 00 = PC, 01 = rs1, 10 = OldPC.
- `alu_src_b` out 2: ALU operand B. 00 = rs2, 01 = constant 4, 10 = immediate.
- `alu_op` out 2: 00 = add, 01 = branch compare, 10 = funct decode.
- `pc_src` out 2: next PC. 00 = ALU result, 01 = ALUOut, 10 = ALUOut with bit 0 cleared.
- `rw_sel` out 2: register write data. 00 = ALUOut, 01 = MDR, 10 = OldPC+4, 11 = immediate.
- `halted`, `illegal`, `bus_err` out 1 each: sticky status flags.
- `instret` out CNT_W: retired-instruction count.

## Operation
- States: BOOT, FETCH, DECODE, EX_R, EX_I, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, ALU_WB, BRANCH, JAL, JALR_CALC, JALR, LUI, HALT, TRAP.
- All outputs are Moore outputs, decoded from state only. Every enable not listed for a state is 0.
- BOOT: all outputs 0. Goes to FETCH unconditionally.
- FETCH: `mem_req`=1, `i_or_d`=0, `alu_src_a`=00, `alu_src_b`=01, `alu_op`=00, `pc_src`=00. `ir_write` and `pc_write` equal `mem_ready`. On `mem_ready`, go to DECODE; otherwise stay in FETCH.
- DECODE: `alu_src_a`=10, `alu_src_b`=10, `alu_op`=00 (branch target into ALUOut). Dispatch on `opcode`:
  - 0110011 → EX_R
  - 0010011 → EX_I
  - 0000011 or 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR_CALC
  - 0110111 → LUI
  - 1111111 → HALT
  - any other value → TRAP with `illegal`=1
- EX_R: `alu_src_a`=01, `alu_src_b`=00, `alu_op`=10. Goes to ALU_WB.
- EX_I: `alu_src_a`=01, `alu_src_b`=10, `alu_op`=10. Goes to ALU_WB.
- ALU_WB: `reg_write`=1, `rw_sel`=00. Goes to FETCH.
- MEM_ADDR: `alu_src_a`=01, `alu_src_b`=10, `alu_op`=00. Goes to MEM_RD for a load, MEM_WR for a store.
- MEM_RD: `mem_req`=1, `i_or_d`=1. Waits for `mem_ready`, then goes to MEM_WB.
- MEM_WB: `reg_write`=1, `rw_sel`=01. Goes to FETCH.
- MEM_WR: `mem_req`=1, `mem_we`=1, `i_or_d`=1. Waits for `mem_ready`, then goes to FETCH.
- BRANCH: `alu_src_a`=01, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_src`=01. Goes to FETCH.
- JAL: `pc_write`=1, `pc_src`=01, `reg_write`=1, `rw_sel`=10. Goes to FETCH.
- JALR_CALC: `alu_src_a`=01, `alu_src_b`=10, `alu_op`=00. Goes to JALR.
- JALR: `pc_write`=1, `pc_src`=10, `reg_write`=1, `rw_sel`=10. Goes to FETCH.
- LUI: `reg_write`=1, `rw_sel`=11. Goes to FETCH.
- HALT: sets `halted`=1. TRAP: holds whichever flag caused it. Both states are absorbing until reset and drive no enables.
- Wait timer: counts cycles in which `mem_req`=1 and `mem_ready`=0, and clears when the request completes.
  - The MAX_WAIT-th consecutive unready cycle forces TRAP with `bus_err`=1.
  - A `mem_ready` arriving in that same cycle wins: the access completes and no trap occurs.
- `mem_ready` while `mem_req`=0 is ignored.
- `instret` increments by 1 on every transition into FETCH from ALU_WB, MEM_WB, MEM_WR (completed), BRANCH, JAL, JALR or LUI. It wraps modulo 2^CNT_W. HALT does not count.

## Timing
- Reset, asynchronous: state = BOOT; `instret`, flags and wait timer = 0; every output = 0.
- Zero-wait-state memory latency (cycles from FETCH entry to next FETCH entry):
  - R/I-type: 4
  - load: 5
  - store: 4
  - branch: 3
  - JAL: 3
  - JALR: 4
  - LUI: 3
- Each cycle of `mem_ready` delay adds one cycle.
- `mem_ready` may be high in the first cycle `mem_req` is raised (zero wait).
- Reset asserted mid-access drops `mem_req` immediately, combinationally through the state.

## Structure
- Package `ctrl_pkg`:
  - opcode localparams
  - `state_t` enum
  - enums for the `alu_src_a`, `alu_src_b`, `alu_op`, `pc_src` and `rw_sel` encodings
- Sub-module `mem_wait_timer`: parametrised by MAX_WAIT; inputs `req`, `ready`; output `timeout`.

## Test plan
- Zero-wait R-type (0110011) with `mem_ready` tied to 1 → FETCH, DECODE, EX_R, ALU_WB, then FETCH; `reg_write`=1 exactly in cycle 4; `instret` 0→1.
- Load with `mem_ready` delayed 3 cycles in MEM_RD → `mem_req`=1 and `i_or_d`=1 held for 4 cycles; instruction takes 8 cycles; `rw_sel`=01 in MEM_WB.
- `mem_ready`=0 forever during FETCH with MAX_WAIT=15 → TRAP after 15 unready cycles, `bus_err`=1, `mem_req`=0 thereafter; `mem_ready` on cycle 15 → no trap.
- Opcode 0000000 at DECODE → TRAP, `illegal`=1. Opcode 1111111 → HALT, `halted`=1, `instret` unchanged, `mem_req` stays 0 for 100 cycles.
- JAL followed by JALR → JAL cycle has `pc_write`=1, `reg_write`=1, `rw_sel`=10, `pc_src`=01; JALR cycle has `pc_src`=10; `instret` +2.
- CNT_W=4, 16 back-to-back LUIs → `instret` wraps 15→0. Assert `rst_n`=0 mid-MEM_WR → all outputs 0 immediately; BOOT then FETCH after release.
